// File: rtl/rough_s_lut.sv
// Three-round byte-wide decryption core: key XOR followed by the PRESENT inverse S-box on every nibble.
// Round keys are derived from KEY0 on the first clock after reset release.
module rough_s_lut #(
  parameter logic [7:0] KEY0 = 8'h3C
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        GLOBAL_EN,
  input  logic [31:0] CipherText,
  output logic [7:0]  OUT1,
  output logic [7:0]  OUT2,
  output logic [7:0]  OUT3,
  output logic [7:0]  OUT4,
  output logic [7:0]  OUT_1,
  output logic [7:0]  OUT_2,
  output logic [7:0]  OUT_3,
  output logic [7:0]  OUT_4,
  output logic [7:0]  K_1,
  output logic [7:0]  K_2,
  output logic [7:0]  K_3,
  output logic        EN,
  output logic        Sel
);

  // state | meaning
  // IDLE  | waiting for GLOBAL_EN with keys loaded; Sel=0 loads CipherText
  // R1-R3 | applying round 1..3 on the working state
  // DONE  | capturing the working state into the result bytes
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_R1   = 3'd1,
    S_R2   = 3'd2,
    S_R3   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] KEY1 = KEY0;
  localparam logic [7:0] KEY2 = {KEY1[6:0], KEY1[7]} ^ 8'h01;
  localparam logic [7:0] KEY3 = {KEY2[6:0], KEY2[7]} ^ 8'h02;

  state_t      state, state_nxt;
  logic        keys_loaded;
  logic [31:0] work;
  logic [31:0] result;
  logic [7:0]  round_key;

  function automatic logic [3:0] inv_s(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h5;
      4'h1: r = 4'hE;
      4'h2: r = 4'hF;
      4'h3: r = 4'h8;
      4'h4: r = 4'hC;
      4'h5: r = 4'h1;
      4'h6: r = 4'h2;
      4'h7: r = 4'hD;
      4'h8: r = 4'hB;
      4'h9: r = 4'h4;
      4'hA: r = 4'h6;
      4'hB: r = 4'h3;
      4'hC: r = 4'h0;
      4'hD: r = 4'h7;
      4'hE: r = 4'h9;
      default: r = 4'hA;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] round_fn(input logic [31:0] s, input logic [7:0] k);
    logic [31:0] x;
    logic [31:0] r;
    x = s ^ {4{k}};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = inv_s(x[i*4 +: 4]);
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (GLOBAL_EN && keys_loaded) state_nxt = S_R1;
      S_R1:    state_nxt = GLOBAL_EN ? S_R2 : S_IDLE;
      S_R2:    state_nxt = GLOBAL_EN ? S_R3 : S_IDLE;
      S_R3:    state_nxt = GLOBAL_EN ? S_DONE : S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    EN  = 1'b0;
    Sel = 1'b0;
    case (state)
      S_R1, S_R2, S_R3: begin
        EN  = 1'b1;
        Sel = 1'b1;
      end
      S_DONE:  Sel = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    round_key = K_1;
    case (state)
      S_R2:    round_key = K_2;
      S_R3:    round_key = K_3;
      default: round_key = K_1;
    endcase
  end

  // Keys load once per reset release; starts are gated on keys_loaded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      keys_loaded <= 1'b0;
      K_1         <= 8'h00;
      K_2         <= 8'h00;
      K_3         <= 8'h00;
    end else if (!keys_loaded) begin
      keys_loaded <= 1'b1;
      K_1         <= KEY1;
      K_2         <= KEY2;
      K_3         <= KEY3;
    end
  end

  // An abort edge (GLOBAL_EN low) leaves both working state and result untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      work   <= '0;
      result <= '0;
    end else if (GLOBAL_EN) begin
      case (state)
        S_IDLE:           if (keys_loaded) work <= CipherText;
        S_R1, S_R2, S_R3: work <= round_fn(work, round_key);
        S_DONE:           result <= work;
        default: ;
      endcase
    end
  end

  assign OUT1  = work[31:24];
  assign OUT2  = work[23:16];
  assign OUT3  = work[15:8];
  assign OUT4  = work[7:0];
  assign OUT_1 = result[31:24];
  assign OUT_2 = result[23:16];
  assign OUT_3 = result[15:8];
  assign OUT_4 = result[7:0];

endmodule

// File: tb/tb_rough_s_lut.sv
// Bench for rough_s_lut: random ciphertexts checked against a table-driven reference,
// with a scoreboard monitor comparing each captured result.
module tb_rough_s_lut;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        GLOBAL_EN = 1'b0;
  logic [31:0] CipherText = '0;
  logic [7:0]  OUT1, OUT2, OUT3, OUT4;
  logic [7:0]  OUT_1, OUT_2, OUT_3, OUT_4;
  logic [7:0]  K_1, K_2, K_3;
  logic        EN, Sel;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic        pend = 1'b0;

  logic [3:0] inv_tab [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                               4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
  logic [7:0] keys [3] = '{8'h3C, 8'h79, 8'hF0};

  rough_s_lut dut (
    .CLK(CLK), .RST_N(RST_N), .GLOBAL_EN(GLOBAL_EN), .CipherText(CipherText),
    .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3), .OUT4(OUT4),
    .OUT_1(OUT_1), .OUT_2(OUT_2), .OUT_3(OUT_3), .OUT_4(OUT_4),
    .K_1(K_1), .K_2(K_2), .K_3(K_3), .EN(EN), .Sel(Sel)
  );

  always #5 CLK = ~CLK;

  wire [31:0] outw = {OUT1, OUT2, OUT3, OUT4};
  wire [31:0] outr = {OUT_1, OUT_2, OUT_3, OUT_4};
  wire [31:0] keyw = {8'h00, K_1, K_2, K_3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-wise lookup on each nibble of (byte ^ key).
  function automatic logic [31:0] model_round(input logic [31:0] s, input logic [7:0] k);
    logic [31:0] r;
    logic [7:0]  b;
    for (int j = 0; j < 4; j++) begin
      b = s[j*8 +: 8] ^ k;
      r[j*8 +: 8] = {inv_tab[b[7:4]], inv_tab[b[3:0]]};
    end
    return r;
  endfunction

  task automatic op(input logic [31:0] ct, input logic [31:0] after_ct, input bit keep);
    logic [31:0] s1, s2, s3;
    s1 = model_round(ct, keys[0]);
    s2 = model_round(s1, keys[1]);
    s3 = model_round(s2, keys[2]);
    CipherText = ct;
    GLOBAL_EN  = 1'b1;
    exp_q.push_back(s3);
    @(posedge CLK);
    #1 CipherText = after_ct;
    @(negedge CLK);
    chk("state after load", outw, ct);
    chk("en r1", {31'b0, EN}, 1);
    chk("sel r1", {31'b0, Sel}, 1);
    @(negedge CLK);
    chk("state round1", outw, s1);
    chk("en r2", {31'b0, EN}, 1);
    @(negedge CLK);
    chk("state round2", outw, s2);
    chk("en r3", {31'b0, EN}, 1);
    @(negedge CLK);
    chk("state round3", outw, s3);
    chk("en done", {31'b0, EN}, 0);
    chk("sel done", {31'b0, Sel}, 1);
    @(posedge CLK);
    #1 if (!keep) GLOBAL_EN = 1'b0;
    @(negedge CLK);
    chk("sel idle", {31'b0, Sel}, 0);
    chk("en idle", {31'b0, EN}, 0);
  endtask

  always @(negedge CLK) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL result unexpected: got %h expected none", outr);
      end else begin
        chk("result", outr, exp_q.pop_front());
      end
    end
    pend <= RST_N && Sel && !EN;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ct, prev, s1;
    repeat (3) @(negedge CLK);
    chk("reset state", outw, 0);
    chk("reset result", outr, 0);
    chk("reset keys", keyw, 0);
    chk("reset en/sel", {30'b0, EN, Sel}, 0);

    // Start requested before keys exist: must wait for the second edge.
    CipherText = 32'hAAAAAAAA;
    GLOBAL_EN  = 1'b1;
    RST_N      = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("keys loaded", keyw, 32'h003C79F0);
    chk("no start on key edge", {30'b0, EN, Sel}, 0);
    chk("state untouched", outw, 0);

    op(32'hAAAAAAAA, 32'h00000000, 1'b1);
    chk("aa result", outr, 32'hD8D8D8D8);
    op(32'h00000000, $urandom, 1'b0);
    chk("zero result", outr, 32'h1C1C1C1C);

    for (int i = 0; i < 10; i++) begin
      ct = $urandom;
      op(ct, $urandom, (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Abort during R2.
    prev = outr;
    ct = $urandom;
    s1 = model_round(ct, keys[0]);
    CipherText = ct;
    GLOBAL_EN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("abort in r2", {30'b0, EN, Sel}, 3);
    GLOBAL_EN = 1'b0;
    @(negedge CLK);
    chk("abort en/sel", {30'b0, EN, Sel}, 0);
    chk("abort state held", outw, s1);
    @(negedge CLK);
    chk("abort result held", outr, prev);
    op($urandom, $urandom, 1'b0);

    // Reset during R3.
    CipherText = $urandom;
    GLOBAL_EN = 1'b1;
    @(posedge CLK);
    repeat (3) @(negedge CLK);
    chk("in r3", {30'b0, EN, Sel}, 3);
    #2 RST_N = 1'b0;
    #1;
    chk("async reset state", outw, 0);
    chk("async reset result", outr, 0);
    chk("async reset keys", keyw, 0);
    chk("async reset en/sel", {30'b0, EN, Sel}, 0);
    GLOBAL_EN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("keys reloaded", keyw, 32'h003C79F0);
    op(32'hAAAAAAAA, $urandom, 1'b0);
    chk("post reset result", outr, 32'hD8D8D8D8);

    @(negedge CLK);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
